sec_mul_tdm_scheduler: RTL and testbench

- Time-division scheduler that shares one iterative shift-add multiplier datapath between two security domains: requester 0 is domain L, requester 1 is domain H.
- Slots have a fixed length and alternate between the domains unconditionally, so domain-H activity cannot change domain-L timing.
- Sits between the two core-side requesters and the shared arithmetic datapath, which is built from the adder and shifter components.

---
 rtl/sec_mul_pkg.sv | 17 +
 rtl/sec_mul_datapath.sv | 49 ++++
 rtl/sec_mul_tdm_scheduler.sv | 122 ++++++++++++
 tb/tb_sec_mul_tdm_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sec_mul_pkg.sv
// Shared encodings for the time-division multiplier scheduler: FSM states,
// domain identifiers and the slot-length helper.
package sec_mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic DOM_L = 1'b0;
  localparam logic DOM_H = 1'b1;

  // One load cycle, p_nbits shift-add cycles, one writeback cycle.
  function automatic int slot_len(input int nbits);
    return nbits + 2;
  endfunction

endpackage

// File: rtl/sec_mul_datapath.sv
// Shared shift-add multiplier datapath: operand/accumulator registers plus one
// LSB-first step per cycle. Scrub clears all state and wins over load/step.
module sec_mul_datapath #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               scrub,
  input  logic [p_nbits-1:0] a_in,
  input  logic [p_nbits-1:0] b_in,
  output logic [p_nbits-1:0] acc
);

  logic [p_nbits-1:0] a_q, b_q, acc_q;
  logic [p_nbits-1:0] addend, sum, a_shl, b_shr;

  // Adder: modulo 2^p_nbits, carry out intentionally dropped.
  assign addend = b_q[0] ? a_q : '0;
  assign sum    = acc_q + addend;

  // Logical shifters.
  assign a_shl = {a_q[p_nbits-2:0], 1'b0};
  assign b_shr = {1'b0, b_q[p_nbits-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (scrub) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (load) begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= '0;
    end else if (step) begin
      a_q   <= a_shl;
      b_q   <= b_shr;
      acc_q <= sum;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/sec_mul_tdm_scheduler.sv
// Fixed-slot TDM scheduler sharing one multiplier between domain L (0) and H (1).
// Optional SEC_MUL_SCRUB_EN clears the datapath registers at every slot wrap.
module sec_mul_tdm_scheduler
  import sec_mul_pkg::*;
#(
  parameter int p_nbits      = 8,
  parameter int p_slot_nbits = 5
) (
  input  logic               clk,
  input  logic               reset,
  output logic               slot_domain,
  input  logic               req0_val,
  output logic               req0_rdy,
  input  logic [p_nbits-1:0] req0_a,
  input  logic [p_nbits-1:0] req0_b,
  output logic               resp0_val,
  input  logic               resp0_rdy,
  output logic [p_nbits-1:0] resp0_data,
  input  logic               req1_val,
  output logic               req1_rdy,
  input  logic [p_nbits-1:0] req1_a,
  input  logic [p_nbits-1:0] req1_b,
  output logic               resp1_val,
  input  logic               resp1_rdy,
  output logic [p_nbits-1:0] resp1_data
);

  localparam int S = slot_len(p_nbits);
  localparam logic [p_slot_nbits-1:0] CNT_LAST     = p_slot_nbits'(S - 1);
  localparam logic [p_slot_nbits-1:0] CNT_CALC_END = p_slot_nbits'(p_nbits);

  logic [p_slot_nbits-1:0] slot_cnt;
  logic [1:0]              state, state_nxt;
  logic                    wrap, window, accept, load, step, scrub;

  logic [1:0]                  req_val, req_rdy, resp_rdy, resp_val;
  logic [1:0][p_nbits-1:0]     req_a, req_b, resp_data;
  logic [p_nbits-1:0]          acc;

  assign req_val  = {req1_val, req0_val};
  assign req_a    = {req1_a, req0_a};
  assign req_b    = {req1_b, req0_b};
  assign resp_rdy = {resp1_rdy, resp0_rdy};

  // Slot timing is free-running and independent of any request activity.
  assign wrap = (slot_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt    <= '0;
      slot_domain <= DOM_L;
    end else if (wrap) begin
      slot_cnt    <= '0;
      slot_domain <= ~slot_domain;
    end else begin
      slot_cnt    <= slot_cnt + 1'b1;
    end
  end

  // Accept window: first cycle of the owner's slot, held closed during reset.
  assign window = reset && (state == ST_IDLE) && (slot_cnt == '0);
  assign accept = |(req_val & req_rdy);
  assign load   = accept;
  assign step   = (state == ST_CALC);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: if (slot_cnt == CNT_CALC_END) state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

`ifdef SEC_MUL_SCRUB_EN
  assign scrub = wrap;
`else
  assign scrub = 1'b0;
`endif

  sec_mul_datapath #(.p_nbits(p_nbits)) u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .scrub (scrub),
    .a_in  (req_a[slot_domain]),
    .b_in  (req_b[slot_domain]),
    .acc   (acc)
  );

  // One-entry response buffer per domain; write and drain are mutually exclusive.
  for (genvar d = 0; d < 2; d++) begin : g_dom
    assign req_rdy[d] = window && (slot_domain == 1'(d)) && !resp_val[d];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        resp_val[d]  <= 1'b0;
        resp_data[d] <= '0;
      end else if ((state == ST_WB) && (slot_domain == 1'(d))) begin
        resp_val[d]  <= 1'b1;
        resp_data[d] <= acc;
      end else if (resp_val[d] && resp_rdy[d]) begin
        resp_val[d]  <= 1'b0;
      end
    end
  end

  assign req0_rdy   = req_rdy[0];
  assign req1_rdy   = req_rdy[1];
  assign resp0_val  = resp_val[0];
  assign resp1_val  = resp_val[1];
  assign resp0_data = resp_data[0];
  assign resp1_data = resp_data[1];

endmodule

// File: tb/tb_sec_mul_tdm_scheduler.sv
// Directed bench for sec_mul_tdm_scheduler (p_nbits=8, slot length 10).
module tb_sec_mul_tdm_scheduler;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          slot_domain;
  logic          req0_val = 1'b0, req0_rdy, resp0_val, resp0_rdy = 1'b1;
  logic [NB-1:0] req0_a = '0, req0_b = '0, resp0_data;
  logic          req1_val = 1'b0, req1_rdy, resp1_val, resp1_rdy = 1'b1;
  logic [NB-1:0] req1_a = '0, req1_b = '0, resp1_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  sec_mul_tdm_scheduler #(.p_nbits(NB), .p_slot_nbits(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .slot_domain (slot_domain),
    .req0_val    (req0_val),
    .req0_rdy    (req0_rdy),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .resp0_val   (resp0_val),
    .resp0_rdy   (resp0_rdy),
    .resp0_data  (resp0_data),
    .req1_val    (req1_val),
    .req1_rdy    (req1_rdy),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .resp1_val   (resp1_val),
    .resp1_rdy   (resp1_rdy),
    .resp1_data  (resp1_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Hold reset 3 cycles with every val high, then release at a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    req0_val = 1'b1;
    req1_val = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy0", req0_rdy, 0);
    chk("rst_rdy1", req1_rdy, 0);
    chk("rst_rv0", resp0_val, 0);
    chk("rst_rv1", resp1_val, 0);
    chk("rst_dom", slot_domain, 0);
    chk("rst_rd0", resp0_data, 0);
    @(negedge clk);
    req0_val  = 1'b0;
    req1_val  = 1'b0;
    resp0_rdy = 1'b1;
    resp1_rdy = 1'b1;
    reset     = 1'b1;
    cyc       = 0;
  endtask

  task automatic stream(input bit sat, input string tag);
    int n0, n1;
    n0 = 0;
    n1 = 0;
    do_reset();
    req0_val = 1'b1; req0_a = 8'd7;   req0_b = 8'd9;
    req1_val = sat;  req1_a = 8'd200; req1_b = 8'd3;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (resp0_val) begin
        chk($sformatf("%s_t0_%0d", tag, n0), cyc, 10 + 20 * n0);
        chk($sformatf("%s_d0_%0d", tag, n0), resp0_data, 63);
        n0++;
      end
      if (resp1_val) begin
        chk($sformatf("%s_t1_%0d", tag, n1), cyc, 20 + 20 * n1);
        chk($sformatf("%s_d1_%0d", tag, n1), resp1_data, 88);
        n1++;
      end
      tick();
    end
    req0_val = 1'b0;
    req1_val = 1'b0;
    chk({tag, "_n0"}, n0, 3);
    chk({tag, "_n1"}, n1, sat ? 2 : 0);
  endtask

  initial begin
    int hits;

    // Basic latency and truncation
    do_reset();
    req0_val = 1'b1; req0_a = 8'd3; req0_b = 8'd5;
    #1;
    chk("c0_rdy0", req0_rdy, 1);
    chk("c0_rdy1", req1_rdy, 0);
    tick();
    req0_val = 1'b0;
    #1 chk("c1_rdy0", req0_rdy, 0);
    while (cyc < 9) tick();
    #1;
    chk("c9_rv0", resp0_val, 0);
    chk("c9_dom", slot_domain, 0);
    tick();
    req1_val = 1'b1; req1_a = 8'd255; req1_b = 8'd255;
    #1;
    chk("c10_rv0", resp0_val, 1);
    chk("c10_rd0", resp0_data, 15);
    chk("c10_dom", slot_domain, 1);
    chk("c10_rdy1", req1_rdy, 1);
    chk("c10_rdy0", req0_rdy, 0);
    tick();
    req1_val = 1'b0;
    #1 chk("c11_rv0", resp0_val, 0);
    while (cyc < 19) tick();
    #1 chk("c19_rv1", resp1_val, 0);
    tick();
    #1;
    chk("c20_rv1", resp1_val, 1);
    chk("c20_rd1", resp1_data, 1);
    chk("c20_dom", slot_domain, 0);

    // Non-interference: identical domain-0 timing with H idle and saturating
    stream(1'b0, "idle");
    stream(1'b1, "sat");

    // Backpressure on domain 0
    do_reset();
    hits = 0;
    resp0_rdy = 1'b0;
    req0_val = 1'b1; req0_a = 8'd2; req0_b = 8'd3;
    for (int i = 0; i < 40; i++) begin
      if (cyc == 30) resp0_rdy = 1'b1;
      if (cyc == 31) begin req0_a = 8'd4; req0_b = 8'd6; end
      #1;
      if (cyc == 0) chk("bp_rdy_c0", req0_rdy, 1);
      else if (req0_rdy) hits++;
      if (cyc == 29) begin
        chk("bp_hold_v", resp0_val, 1);
        chk("bp_hold_d", resp0_data, 6);
      end
      if (cyc == 31) chk("bp_drained", resp0_val, 0);
      tick();
    end
    #1;
    chk("bp_blocked", hits, 0);
    chk("bp_resume", req0_rdy, 1);
    while (cyc < 50) tick();
    #1;
    chk("bp_rv", resp0_val, 1);
    chk("bp_rd", resp0_data, 24);
    req0_val = 1'b0;

    // Reset during CALC aborts the operation
    do_reset();
    req0_val = 1'b1; req0_a = 8'd3; req0_b = 8'd5;
    tick();
    req0_val = 1'b0;
    while (cyc < 4) tick();
    reset = 1'b0;
    #1;
    chk("mr_rdy0", req0_rdy, 0);
    chk("mr_dom", slot_domain, 0);
    tick();
    tick();
    reset = 1'b1;
    cyc = 0;
    hits = 0;
    for (int i = 0; i < 25; i++) begin
      #1;
      if (resp0_val || resp1_val) hits++;
      if (cyc == 9)  chk("mr_dom_c9", slot_domain, 0);
      if (cyc == 10) chk("mr_dom_c10", slot_domain, 1);
      tick();
    end
    chk("mr_noresp", hits, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1);
  end

endmodule
